multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle control FSM for the 32-bit CPU; generational successor to the single-cycle decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and drives the existing datapath select/enable signals from the registered state.
- Adds a data-memory req/ack handshake with a wait-state timeout, plus illegal-opcode detection with sticky error flags.
- Sits between the instruction register, the datapath muxes and the data memory.

Parameters:
- TIMEOUT, 16: maximum cycles in MEM without mem_ack before the FSM aborts.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.
- HALT_ON_ILLEGAL, 1: 1 = an illegal opcode enters HALT; 0 = it is retired as a NOP and only the flag is set.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr  in  32  current instruction word; sampled only in IF.
- alu_zero  in  1  ALU zero flag; valid in EX.
- mem_ack  in  1  data memory has completed the request.
- ir_lden  out  1  load the instruction register.
- pc_sel  out  1  0 = PC+4, 1 = branch target.
- pc_lden  out  1  PC load enable.
- rf_wren  out  1  register-file write enable.
- rf_wrdata_sel  out  1  0 = ALU result, 1 = memory data.
- rf_b_sel  out  1  register-file B read address select.
- alu_bin_sel  out  1  0 = register B, 1 = immediate.
- alu_func  out  4  ALU operation.
- mem_req  out  1  data memory request.
- mem_wren  out  1  data memory write (valid with mem_req).
- mem_byte  out  1  1 = byte access, 0 = word access.
- state  out  3  current FSM state, for debug.
- illegal_op  out  1  sticky illegal-opcode flag.
- timeout_err  out  1  sticky memory-timeout flag.

Behaviour:
- States: IF=0, DEC=1, EX=2, MEM=3, WB=4, HALT=5. The codes 6 and 7 go to IF on the next cycle.
- Reset: state=IF, wait counter=0, captured op/func=0, illegal_op=0, timeout_err=0.
- Reset effect on outputs: all outputs are decoded from state, so out of reset every output is 0 except ir_lden=1.
- Reset mid-instruction aborts that instruction with no further enables.
- All outputs are combinational decodes of the registered state and the captured op/func only; they never depend on the live instr except through the capture.
- IF:
  - ir_lden=1.
  - Capture op=instr[31:26], func=instr[3:0] and nop=(instr==0).
  - Go to DEC.
- DEC:
  - NOP: pc_lden=1, pc_sel=0, go to IF (2 cycles total).
  - Illegal op: set illegal_op. Go to HALT if HALT_ON_ILLEGAL=1, otherwise pc_lden=1 and go to IF.
  - Otherwise go to EX.
- EX, alu_func per opcode:
  - 100000 (R-type): alu_func=func.
  - 110000 and the four memory ops: 0000.
  - 111000 and 111001: 1111.
  - 110010: 0010.
  - 110011: 0011.
  - 000000 and 000001: 0001.
  - 111111: 0111.
- EX, mux selects:
  - alu_bin_sel=1 for every op except R-type, beq and bne.
  - rf_b_sel=1 for every op except R-type.
- EX, branches (3 cycles total): pc_lden=1, go to IF.
  - 111111: pc_sel=1.
  - 000000 (beq): pc_sel=alu_zero.
  - 000001 (bne): pc_sel=!alu_zero.
- EX, memory ops (000011, 000111, 001111, 011111): go to MEM with the counter cleared. All other ops go to WB.
- MEM:
  - mem_req=1, held until mem_ack.
  - mem_wren=1 for 000111 and 011111.
  - mem_byte=1 for 000011 and 000111.
  - alu_func=0000 and alu_bin_sel=1 are held.
  - The counter increments each cycle mem_ack=0.
  - mem_ack=1: loads go to WB. Stores assert pc_lden=1 in that same cycle and go to IF.
  - Counter reaches TIMEOUT with mem_ack=0: set timeout_err and go to HALT; mem_req drops next cycle.
  - mem_ack arriving in the same cycle as the counter reaches TIMEOUT: the ack wins and no error is raised.
  - mem_ack outside MEM is ignored.
- WB:
  - rf_wren=1 and pc_lden=1, go to IF.
  - rf_wrdata_sel=1 for loads.
  - The EX alu_func and selects are held so the ALU result is stable during writeback.
- HALT: all enables 0. HALT is left only by reset.
- Invariant: pc_lden is asserted exactly once per retired instruction; rf_wren and mem_req are never both 1.
- Cycle counts:
  - ALU and immediate ops: 4.
  - Branches: 3.
  - Loads: 5 + wait cycles.
  - Stores: 4 + wait cycles.
  - NOP: 2.

Test Plan:
1. Reset, then instr=0x00000000 → state IF→DEC→IF. pc_lden=1 only in DEC, rf_wren never 1.
2. instr=0x80000002 (R-type, func=2) → EX alu_func=0010, alu_bin_sel=0. WB rf_wren=1, rf_wrdata_sel=0, pc_lden=1. Total 4 cycles.
3. beq (op 000000): alu_zero=1 → EX pc_sel=1, pc_lden=1. Repeat with alu_zero=0 → pc_sel=0. bne (op 000001) with alu_zero=0 → pc_sel=1. Each takes 3 cycles.
4. lb (op 000011), mem_ack delayed 3 cycles → mem_req=1 for 4 cycles with mem_byte=1, mem_wren=0. Then WB with rf_wrdata_sel=1. Total 8 cycles.
5. sw (op 011111), TIMEOUT=16, mem_ack held 0 → timeout_err=1 after 16 MEM cycles, state=5 (HALT). Outputs stay quiet until reset, and reset clears the flag.
6. op=101010 with HALT_ON_ILLEGAL=1 → illegal_op=1, state=5. With HALT_ON_ILLEGAL=0 → pc_lden=1 in DEC, return to IF, flag stays set. Also assert reset in MEM → next cycle state=IF, mem_req=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 32-bit CPU: sequences IF/DEC/EX/MEM/WB and drives
// datapath selects/enables, data-memory handshake with timeout, and sticky error flags.
module multicycle_control #(
   parameter int TIMEOUT         = 16,
   parameter int CNT_W           = 5,
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        alu_zero,
   input  logic        mem_ack,
   output logic        ir_lden,
   output logic        pc_sel,
   output logic        pc_lden,
   output logic        rf_wren,
   output logic        rf_wrdata_sel,
   output logic        rf_b_sel,
   output logic        alu_bin_sel,
   output logic [3:0]  alu_func,
   output logic        mem_req,
   output logic        mem_wren,
   output logic        mem_byte,
   output logic [2:0]  state,
   output logic        illegal_op,
   output logic        timeout_err
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_DEC  = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b100000;
   localparam logic [5:0] OP_BEQ   = 6'b000000;
   localparam logic [5:0] OP_BNE   = 6'b000001;
   localparam logic [5:0] OP_JMP   = 6'b111111;
   localparam logic [5:0] OP_LB    = 6'b000011;
   localparam logic [5:0] OP_SB    = 6'b000111;
   localparam logic [5:0] OP_LW    = 6'b001111;
   localparam logic [5:0] OP_SW    = 6'b011111;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]       op_q, op_d;
   logic [3:0]       func_q, func_d;
   logic             nop_q, nop_d;
   logic             ill_q, ill_d;
   logic             to_q, to_d;

   logic is_rtype_s, is_beq_s, is_bne_s, is_jmp_s, is_load_s, is_store_s;

   function automatic logic legal_op(input logic [5:0] op);
      case (op)
         6'b100000, 6'b110000, 6'b111000, 6'b111001, 6'b110010, 6'b110011,
         6'b000000, 6'b000001, 6'b111111,
         6'b000011, 6'b000111, 6'b001111, 6'b011111: legal_op = 1'b1;
         default:                                    legal_op = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] ex_alu(input logic [5:0] op, input logic [3:0] func);
      case (op)
         6'b100000:                     ex_alu = func;
         6'b111000, 6'b111001:          ex_alu = 4'b1111;
         6'b110010:                     ex_alu = 4'b0010;
         6'b110011:                     ex_alu = 4'b0011;
         6'b000000, 6'b000001:          ex_alu = 4'b0001;
         6'b111111:                     ex_alu = 4'b0111;
         default:                       ex_alu = 4'b0000;
      endcase
   endfunction

   assign is_rtype_s = (op_q == OP_RTYPE);
   assign is_beq_s   = (op_q == OP_BEQ);
   assign is_bne_s   = (op_q == OP_BNE);
   assign is_jmp_s   = (op_q == OP_JMP);
   assign is_load_s  = (op_q == OP_LB) || (op_q == OP_LW);
   assign is_store_s = (op_q == OP_SB) || (op_q == OP_SW);

   // State, capture and sticky-flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IF;
         cnt_q   <= '0;
         op_q    <= 6'd0;
         func_q  <= 4'd0;
         nop_q   <= 1'b0;
         ill_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         func_q  <= func_d;
         nop_q   <= nop_d;
         ill_q   <= ill_d;
         to_q    <= to_d;
      end
   end

   // Next-state and output decode from the registered state and captured opcode
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      func_d        = func_q;
      nop_d         = nop_q;
      ill_d         = ill_q;
      to_d          = to_q;
      ir_lden       = 1'b0;
      pc_sel        = 1'b0;
      pc_lden       = 1'b0;
      rf_wren       = 1'b0;
      rf_wrdata_sel = 1'b0;
      rf_b_sel      = 1'b0;
      alu_bin_sel   = 1'b0;
      alu_func      = 4'b0000;
      mem_req       = 1'b0;
      mem_wren      = 1'b0;
      mem_byte      = 1'b0;
      case (state_q)
         S_IF: begin
            ir_lden = 1'b1;
            op_d    = instr[31:26];
            func_d  = instr[3:0];
            nop_d   = (instr == 32'd0);
            state_d = S_DEC;
         end
         S_DEC: begin
            if (nop_q) begin
               pc_lden = 1'b1;
               state_d = S_IF;
            end else if (!legal_op(op_q)) begin
               ill_d = 1'b1;
               if (HALT_ON_ILLEGAL) begin
                  state_d = S_HALT;
               end else begin
                  pc_lden = 1'b1;
                  state_d = S_IF;
               end
            end else begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            alu_func    = ex_alu(op_q, func_q);
            alu_bin_sel = ~(is_rtype_s | is_beq_s | is_bne_s);
            rf_b_sel    = ~is_rtype_s;
            if (is_jmp_s || is_beq_s || is_bne_s) begin
               pc_lden = 1'b1;
               pc_sel  = is_jmp_s | (is_beq_s & alu_zero) | (is_bne_s & ~alu_zero);
               state_d = S_IF;
            end else if (is_load_s || is_store_s) begin
               cnt_d   = '0;
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            mem_req     = 1'b1;
            mem_wren    = is_store_s;
            mem_byte    = (op_q == OP_LB) || (op_q == OP_SB);
            alu_bin_sel = 1'b1;
            rf_b_sel    = 1'b1;
            // An ack on the final allowed cycle still completes the access
            if (mem_ack) begin
               if (is_store_s) begin
                  pc_lden = 1'b1;
                  state_d = S_IF;
               end else begin
                  state_d = S_WB;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == TIMEOUT_C) begin
                  to_d    = 1'b1;
                  state_d = S_HALT;
               end else begin
                  state_d = S_MEM;
               end
            end
         end
         S_WB: begin
            alu_func      = ex_alu(op_q, func_q);
            alu_bin_sel   = ~(is_rtype_s | is_beq_s | is_bne_s);
            rf_b_sel      = ~is_rtype_s;
            rf_wren       = 1'b1;
            rf_wrdata_sel = is_load_s;
            pc_lden       = 1'b1;
            state_d       = S_IF;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IF;
         end
      endcase
   end

   assign state       = state_q;
   assign illegal_op  = ill_q;
   assign timeout_err = to_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle sequences built from the
// instruction-level behaviour, applied to a halting and a non-halting instance.
module tb_multicycle_control;

   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic       ir_lden;
      logic       pc_sel;
      logic       pc_lden;
      logic       rf_wren;
      logic       rf_wrdata_sel;
      logic       rf_b_sel;
      logic       alu_bin_sel;
      logic [3:0] alu_func;
      logic       mem_req;
      logic       mem_wren;
      logic       mem_byte;
      logic [2:0] state;
      logic       illegal_op;
      logic       timeout_err;
   } outs_t;

   typedef struct {
      logic [31:0] instr;
      logic        az;
      logic        ack;
      logic        rst;
      logic [1:0]  mask;
      logic [63:0] tag;
      outs_t       exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, alu_zero, mem_ack;
   logic [31:0] instr;

   logic       h_ir, h_psel, h_plden, h_rfw, h_wrsel, h_bsel, h_binsel, h_req, h_wren, h_byte, h_ill, h_to;
   logic [3:0] h_af;
   logic [2:0] h_st;
   logic       n_ir, n_psel, n_plden, n_rfw, n_wrsel, n_bsel, n_binsel, n_req, n_wren, n_byte, n_ill, n_to;
   logic [3:0] n_af;
   logic [2:0] n_st;
   outs_t      act_h, act_n;

   always #5 clk = ~clk;

   multicycle_control #(.TIMEOUT(TIMEOUT), .CNT_W(5), .HALT_ON_ILLEGAL(1'b1)) dut_h (
      .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero), .mem_ack(mem_ack),
      .ir_lden(h_ir), .pc_sel(h_psel), .pc_lden(h_plden), .rf_wren(h_rfw),
      .rf_wrdata_sel(h_wrsel), .rf_b_sel(h_bsel), .alu_bin_sel(h_binsel), .alu_func(h_af),
      .mem_req(h_req), .mem_wren(h_wren), .mem_byte(h_byte), .state(h_st),
      .illegal_op(h_ill), .timeout_err(h_to));

   multicycle_control #(.TIMEOUT(TIMEOUT), .CNT_W(5), .HALT_ON_ILLEGAL(1'b0)) dut_n (
      .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero), .mem_ack(mem_ack),
      .ir_lden(n_ir), .pc_sel(n_psel), .pc_lden(n_plden), .rf_wren(n_rfw),
      .rf_wrdata_sel(n_wrsel), .rf_b_sel(n_bsel), .alu_bin_sel(n_binsel), .alu_func(n_af),
      .mem_req(n_req), .mem_wren(n_wren), .mem_byte(n_byte), .state(n_st),
      .illegal_op(n_ill), .timeout_err(n_to));

   assign act_h = {h_ir, h_psel, h_plden, h_rfw, h_wrsel, h_bsel, h_binsel, h_af,
                   h_req, h_wren, h_byte, h_st, h_ill, h_to};
   assign act_n = {n_ir, n_psel, n_plden, n_rfw, n_wrsel, n_bsel, n_binsel, n_af,
                   n_req, n_wren, n_byte, n_st, n_ill, n_to};

   vec_t        vq[$];
   vec_t        tbl[0:6];
   logic        m_ill, m_to;
   logic [1:0]  cur_mask;
   logic [63:0] cur_tag;
   int          n_chk, n_fail;

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic [31:0] rw();
      return $urandom;
   endfunction

   function automatic outs_t mk(input logic [2:0] st, input logic [6:0] ctl,
                                input logic [3:0] af, input logic [2:0] mb);
      return {ctl, af, mb, st, 2'b00};
   endfunction

   function automatic vec_t mkv(input logic [31:0] ins, input logic rst, input logic [1:0] mask,
                                input logic [63:0] tag, input outs_t o);
      vec_t v;
      v.instr = ins; v.az = 1'b0; v.ack = 1'b0; v.rst = rst; v.mask = mask; v.tag = tag; v.exp = o;
      return v;
   endfunction

   function automatic outs_t base(input logic [2:0] st);
      outs_t o;
      o = '0;
      o.state = st; o.illegal_op = m_ill; o.timeout_err = m_to;
      return o;
   endfunction

   function automatic bit legal(input logic [5:0] op);
      logic [5:0] ok[13] = '{6'b100000, 6'b110000, 6'b111000, 6'b111001, 6'b110010, 6'b110011,
                             6'b000000, 6'b000001, 6'b111111, 6'b000011, 6'b000111,
                             6'b001111, 6'b011111};
      foreach (ok[i]) if (ok[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [3:0] fn);
      if (op == 6'b100000) return fn;
      if (op == 6'b111000 || op == 6'b111001) return 4'b1111;
      if (op == 6'b110010) return 4'b0010;
      if (op == 6'b110011) return 4'b0011;
      if (op == 6'b000000 || op == 6'b000001) return 4'b0001;
      if (op == 6'b111111) return 4'b0111;
      return 4'b0000;
   endfunction

   task automatic push(input logic [31:0] ins, input logic az, input logic ack,
                       input logic rst, input outs_t o);
      vec_t v;
      v.instr = ins; v.az = az; v.ack = ack; v.rst = rst;
      v.mask = cur_mask; v.tag = cur_tag; v.exp = o;
      vq.push_back(v);
      if (rst) begin
         m_ill = 1'b0;
         m_to  = 1'b0;
      end
   endtask

   task automatic push_halt(input int n);
      for (int i = 0; i < n; i++) push(rw(), rb(), rb(), 1'b0, base(3'd5));
   endtask

   task automatic push_reset(input logic [2:0] st);
      outs_t o;
      o = base(st);
      o.ir_lden = (st == 3'd0);
      push(rw(), rb(), rb(), 1'b1, o);
   endtask

   // Expected cycles of one instruction; wt = MEM cycles before ack, rst_k = MEM cycle to reset in
   task automatic gen(input logic [31:0] ins, input logic az, input int wt, input int rst_k,
                      input bit hoi, output bit halted);
      outs_t      o;
      logic [5:0] op;
      logic [3:0] fn;
      logic       ack, ld, st, rt;
      op = ins[31:26]; fn = ins[3:0]; halted = 1'b0;
      ld = (op == 6'b000011 || op == 6'b001111);
      st = (op == 6'b000111 || op == 6'b011111);
      rt = (op == 6'b100000);
      o = base(3'd0); o.ir_lden = 1'b1;
      push(ins, rb(), rb(), 1'b0, o);
      o = base(3'd1);
      if (ins == 32'd0) begin
         o.pc_lden = 1'b1;
         push(rw(), rb(), rb(), 1'b0, o);
         return;
      end
      if (!legal(op)) begin
         o.pc_lden = !hoi;
         push(rw(), rb(), rb(), 1'b0, o);
         m_ill = 1'b1; halted = hoi;
         return;
      end
      push(rw(), rb(), rb(), 1'b0, o);
      o = base(3'd2);
      o.alu_func = alu_of(op, fn);
      o.alu_bin_sel = !(rt || op == 6'b000000 || op == 6'b000001);
      o.rf_b_sel = !rt;
      if (op == 6'b111111 || op == 6'b000000 || op == 6'b000001) begin
         o.pc_lden = 1'b1;
         o.pc_sel = (op == 6'b111111) ? 1'b1 : ((op == 6'b000000) ? az : !az);
         push(rw(), az, rb(), 1'b0, o);
         return;
      end
      push(rw(), az, rb(), 1'b0, o);
      if (ld || st) begin
         for (int k = 0; k < TIMEOUT; k++) begin
            ack = (k == wt);
            o = base(3'd3);
            o.mem_req = 1'b1; o.mem_wren = st;
            o.mem_byte = (op == 6'b000011 || op == 6'b000111);
            o.alu_bin_sel = 1'b1; o.rf_b_sel = 1'b1;
            if (k == rst_k) begin
               push(rw(), rb(), 1'b0, 1'b1, o);
               return;
            end
            o.pc_lden = ack && st;
            push(rw(), rb(), ack, 1'b0, o);
            if (ack && st) return;
            if (ack) break;
            if (k == TIMEOUT - 1) begin
               m_to = 1'b1; halted = 1'b1;
               return;
            end
         end
      end
      o = base(3'd4);
      o.alu_func = alu_of(op, fn);
      o.alu_bin_sel = !rt; o.rf_b_sel = !rt;
      o.rf_wren = 1'b1; o.pc_lden = 1'b1; o.rf_wrdata_sel = ld;
      push(rw(), rb(), rb(), 1'b0, o);
   endtask

   initial begin
      bit         hl;
      logic [5:0] ops[14] = '{6'b100000, 6'b110000, 6'b111000, 6'b111001, 6'b110010, 6'b110011,
                              6'b000000, 6'b000001, 6'b111111, 6'b000011, 6'b000111,
                              6'b001111, 6'b011111, 6'b000000};
      logic [31:0] ri;
      n_chk = 0; n_fail = 0; m_ill = 1'b0; m_to = 1'b0; cur_mask = 2'b11;

      // Reset, NOP, then R-type func=2
      tbl[0] = mkv(32'h0000_0000, 1'b1, 2'b00, "reset", mk(3'd0, 7'b0000000, 4'h0, 3'b000));
      tbl[1] = mkv(32'h0000_0000, 1'b0, 2'b11, "nop_if", mk(3'd0, 7'b1000000, 4'h0, 3'b000));
      tbl[2] = mkv(32'hFFFF_FFFF, 1'b0, 2'b11, "nop_dec", mk(3'd1, 7'b0010000, 4'h0, 3'b000));
      tbl[3] = mkv(32'h8000_0002, 1'b0, 2'b11, "r_if", mk(3'd0, 7'b1000000, 4'h0, 3'b000));
      tbl[4] = mkv(32'hFFFF_FFFF, 1'b0, 2'b11, "r_dec", mk(3'd1, 7'b0000000, 4'h0, 3'b000));
      tbl[5] = mkv(32'h0000_0000, 1'b0, 2'b11, "r_ex", mk(3'd2, 7'b0000000, 4'h2, 3'b000));
      tbl[6] = mkv(32'h1234_5678, 1'b0, 2'b11, "r_wb", mk(3'd4, 7'b0011000, 4'h2, 3'b000));
      for (int i = 0; i < 7; i++) vq.push_back(tbl[i]);

      cur_tag = "branch";
      gen(32'h0000_0010, 1'b1, 0, -1, 1'b1, hl);
      gen(32'h0000_0010, 1'b0, 0, -1, 1'b1, hl);
      gen(32'h0400_0000, 1'b0, 0, -1, 1'b1, hl);
      gen(32'h0400_0000, 1'b1, 0, -1, 1'b1, hl);
      gen(32'hFC00_0000, 1'b0, 0, -1, 1'b1, hl);
      cur_tag = "mem";
      gen(32'h0C00_0000, 1'b0, 3, -1, 1'b1, hl);
      gen(32'h3C00_0004, 1'b0, 0, -1, 1'b1, hl);
      gen(32'h1C00_0000, 1'b0, 0, -1, 1'b1, hl);
      gen(32'h7C00_0000, 1'b0, TIMEOUT - 1, -1, 1'b1, hl);
      cur_tag = "timeout";
      gen(32'h7C00_0000, 1'b0, 99, -1, 1'b1, hl);
      push_halt(5);
      push_reset(3'd5);
      cur_tag = "ill_halt";
      cur_mask = 2'b01;
      gen(32'hA800_0000, 1'b0, 0, -1, 1'b1, hl);
      push_halt(4);
      push_reset(3'd5);
      cur_tag = "ill_nop";
      cur_mask = 2'b10;
      gen(32'hA800_0000, 1'b0, 0, -1, 1'b0, hl);
      gen(32'h8000_0005, 1'b0, 0, -1, 1'b0, hl);
      push_reset(3'd0);
      cur_mask = 2'b11;
      cur_tag = "rst_mem";
      gen(32'h3C00_0000, 1'b0, 99, 1, 1'b1, hl);
      gen(32'h0000_0000, 1'b0, 0, -1, 1'b1, hl);

      cur_tag = "random";
      for (int i = 0; i < 120; i++) begin
         ri = {ops[$urandom_range(0, 13)], 26'($urandom)};
         if ($urandom_range(0, 9) == 0) ri = 32'd0;
         gen(ri, rb(), $urandom_range(0, TIMEOUT - 2), -1, 1'b1, hl);
      end

      for (int i = 0; i < vq.size(); i++) begin
         reset = vq[i].rst; instr = vq[i].instr; alu_zero = vq[i].az; mem_ack = vq[i].ack;
         @(negedge clk);
         if (vq[i].mask[0]) begin
            n_chk++;
            if (act_h !== vq[i].exp) begin
               n_fail++;
               $display("FAIL %s vec %0d halt-inst: got %h required %h", vq[i].tag, i, act_h, vq[i].exp);
            end
         end
         if (vq[i].mask[1]) begin
            n_chk++;
            if (act_n !== vq[i].exp) begin
               n_fail++;
               $display("FAIL %s vec %0d nohalt-inst: got %h required %h", vq[i].tag, i, act_n, vq[i].exp);
            end
         end
         @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
